prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Write-side counterpart of the instruction fetch path: fills the 4K x 8 program memory that the program counter and fetch stage later read.
- Accepts a nibble stream, high nibble first then low nibble, matching the fetch split of instruction byte into [7:4] and [3:0].
- Assembles each pair into a byte and writes it to sequential addresses starting at a loaded base.
- Sits between a host/debug nibble source and the memory write port.

Parameters:
- ADDR_W, 12, memory address width (4096 locations).
- LEN_W, 13, byte-count width; must equal ADDR_W+1 so a full 4096-byte load is expressible.

Ports:
- Clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high.
- start  input  1  begin a load; sampled only in IDLE.
- base  input  ADDR_W  first write address, captured on start.
- len  input  LEN_W  number of bytes to write, captured on start.
- abort  input  1  synchronous cancel of an active load.
- nib_valid  input  1  source has a nibble on nib.
- nib  input  4  nibble data.
- nib_ready  output  1  loader accepts a nibble this cycle.
- mem_we  output  1  memory write strobe, one cycle per byte.
- mem_addr  output  ADDR_W  write address.
- mem_wdata  output  8  write data, {high nibble, low nibble}.
- busy  output  1  high in any state except IDLE.
- done  output  1  one-cycle pulse at load completion.
- count  output  LEN_W  bytes written since the last start.
- csum  output  8  running checksum (see Optional Feature).

Behaviour:
- Reset values: state=IDLE; nib_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, count=0, csum=0.
- Handshake: a nibble transfers on a rising edge with nib_valid=1 and nib_ready=1. nib_valid may toggle freely; no transfer occurs without ready.
- FSM states: IDLE, HIGH, LOW, WRITE, DONE.
- IDLE:
  - nib_ready=0.
  - start=1 captures base into addr and len into rem, and clears count (and csum).
  - If len==0, go to DONE with no writes; otherwise go to HIGH.
- HIGH: nib_ready=1. On transfer, hi<=nib, go to LOW.
- LOW: nib_ready=1. On transfer, lo<=nib, go to WRITE.
- WRITE:
  - nib_ready=0; mem_we=1 for exactly this cycle, with mem_addr=addr and mem_wdata={hi,lo}.
  - On exit: addr<=addr+1 mod 2^ADDR_W (0xFFF wraps to 0x000); rem<=rem-1; count<=count+1.
  - If rem==1, go to DONE; else go to HIGH.
- DONE: done=1 for one cycle, busy=1, then go to IDLE.
- Timing: the first write strobe occurs one cycle after the low-nibble transfer. Minimum 3 cycles per byte.
- mem_addr and mem_wdata hold their last values when mem_we=0.
- start while not in IDLE is ignored.
- abort=1 in HIGH, LOW or WRITE: go to IDLE next edge. No mem_we in that cycle, and no done pulse. A partial nibble is discarded; count keeps the bytes already written. abort has priority over start and over handshake.
- abort in IDLE or DONE: no effect; the done pulse still completes.
- reset asserted mid-load: immediate return to reset values with no further writes.
- len > 2^ADDR_W is not allowed. If applied, addresses wrap and overwrite; count still reaches len.

Optional Feature:
- Macro PROG_LOADER_CSUM_EN.
- Defined: csum is cleared on start and updated with csum<=csum+mem_wdata (mod 256) in each WRITE cycle. It holds after DONE until the next start or reset.
- Undefined: the csum port still exists, is driven constant 8'h00, and no accumulator is synthesized.

Test Plan:
- Basic load: base=0x010, len=3, nibbles 1,2,3,4,5,6 back-to-back -> writes 0x12@0x010, 0x34@0x011, 0x56@0x012; one mem_we per byte; done pulses once; count=3; csum=0x9C with PROG_LOADER_CSUM_EN defined.
- Wrap: base=0xFFF, len=2, bytes 0xAB, 0xCD -> writes at 0xFFF then 0x000; done pulses; count=2.
- Zero length: start with len=0 -> no mem_we; done pulses 1 cycle after start; busy high for exactly that cycle.
- Backpressure/gaps: nib_valid toggled 1-0-0-1 with random idle cycles -> only handshaken nibbles are used; nib_ready=0 in IDLE and WRITE; bytes are correct.
- Abort: base=0x100, len=4; abort after 1 byte plus the high nibble of the second byte -> exactly one write (0x100); no done; count=1; next start behaves normally.
- Reset mid-load: assert reset between the LOW transfer and WRITE -> no mem_we; all outputs at reset values asynchronously.

Source files
------------

// File: rtl/prog_loader_if.sv
// ============================================================================
// prog_loader_if - nibble stream in / memory write port out for prog_loader.
// Rev 1.0
// ============================================================================
`default_nettype none

interface prog_loader_if #(
   parameter int ADDR_W = 12
);
   logic              nib_valid;
   logic [3:0]        nib;
   logic              nib_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;

   modport master (
      output nib_valid, nib,
      input  nib_ready, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  nib_valid, nib,
      output nib_ready, mem_we, mem_addr, mem_wdata
   );
endinterface

`default_nettype wire

// File: rtl/prog_loader.sv
// ============================================================================
// prog_loader - assembles hi/lo nibble pairs into bytes written to sequential
// program-memory addresses. Optional checksum: PROG_LOADER_CSUM_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module prog_loader #(
   parameter int ADDR_W = 12,
   parameter int LEN_W  = 13
) (
   input  logic              Clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base,
   input  logic [LEN_W-1:0]  len,
   input  logic              abort,
   prog_loader_if.slave      bus,
   output logic              busy,
   output logic              done,
   output logic [LEN_W-1:0]  count,
   output logic [7:0]        csum
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      HIGH  = 3'd1,
      LOW   = 3'd2,
      WRITE = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] addr;
   logic [LEN_W-1:0]  rem;
   logic [3:0]        hi;
   logic              ready_q;
   logic              we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [7:0]        wdata_q;

   // abort must win the same cycle it is seen, so it masks the registered strobes
   assign bus.nib_ready = ready_q & ~abort;
   assign bus.mem_we    = we_q & ~abort;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = wdata_q;

   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         addr       <= '0;
         rem        <= '0;
         hi         <= '0;
         ready_q    <= 1'b0;
         we_q       <= 1'b0;
         mem_addr_q <= '0;
         wdata_q    <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         count      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  addr  <= base;
                  rem   <= len;
                  count <= '0;
                  busy  <= 1'b1;
                  if (len == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state   <= HIGH;
                     ready_q <= 1'b1;
                  end
               end
            end
            HIGH: begin
               if (abort) begin
                  state   <= IDLE;
                  ready_q <= 1'b0;
                  busy    <= 1'b0;
               end else if (bus.nib_valid) begin
                  hi    <= bus.nib;
                  state <= LOW;
               end
            end
            LOW: begin
               if (abort) begin
                  state   <= IDLE;
                  ready_q <= 1'b0;
                  busy    <= 1'b0;
               end else if (bus.nib_valid) begin
                  wdata_q    <= {hi, bus.nib};
                  mem_addr_q <= addr;
                  we_q       <= 1'b1;
                  ready_q    <= 1'b0;
                  state      <= WRITE;
               end
            end
            WRITE: begin
               we_q <= 1'b0;
               if (abort) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  addr  <= addr + ADDR_W'(1);
                  rem   <= rem - LEN_W'(1);
                  count <= count + LEN_W'(1);
                  if (rem == LEN_W'(1)) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state   <= HIGH;
                     ready_q <= 1'b1;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
            default: begin
               state   <= IDLE;
               ready_q <= 1'b0;
               we_q    <= 1'b0;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

`ifdef PROG_LOADER_CSUM_EN
   logic [7:0] csum_q;

   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         csum_q <= '0;
      end else if (state == IDLE && start) begin
         csum_q <= '0;
      end else if (state == WRITE && !abort) begin
         csum_q <= csum_q + wdata_q;
      end
   end

   assign csum = csum_q;
`else
   assign csum = 8'h00;
`endif

endmodule

`default_nettype wire

// File: tb/tb_prog_loader.sv
// ============================================================================
// tb_prog_loader - directed self-checking bench for prog_loader.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_prog_loader;

   localparam int ADDR_W = 12;
   localparam int LEN_W  = 13;
`ifdef PROG_LOADER_CSUM_EN
   localparam bit CS_ON = 1'b1;
`else
   localparam bit CS_ON = 1'b0;
`endif

   logic              Clk;
   logic              reset;
   logic              start;
   logic [ADDR_W-1:0] base;
   logic [LEN_W-1:0]  len;
   logic              abort;
   logic              busy;
   logic              done;
   logic [LEN_W-1:0]  count;
   logic [7:0]        csum;

   prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

   prog_loader #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
      .Clk   (Clk),
      .reset (reset),
      .start (start),
      .base  (base),
      .len   (len),
      .abort (abort),
      .bus   (bus.slave),
      .busy  (busy),
      .done  (done),
      .count (count),
      .csum  (csum)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Edge monitor: logs every write strobe, done pulse and busy cycle.
   logic [19:0] wr_log [0:63];
   int          wr_n;
   int          done_n;
   int          busy_n;

   initial begin
      wr_n   = 0;
      done_n = 0;
      busy_n = 0;
   end

   always @(posedge Clk) begin
      if (bus.mem_we) begin
         if (wr_n < 64) wr_log[wr_n] = {bus.mem_addr, bus.mem_wdata};
         wr_n = wr_n + 1;
      end
      if (done) done_n = done_n + 1;
      if (busy) busy_n = busy_n + 1;
   end

   int n_checks;
   int n_fail;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] cs_exp(input logic [7:0] v);
      return CS_ON ? {24'd0, v} : 32'd0;
   endfunction

   // Called at a falling edge; returns at the falling edge after the transfer.
   task automatic send_nib(input logic [3:0] n);
      int t;
      t = 0;
      bus.nib_valid = 1'b1;
      bus.nib       = n;
      while (!bus.nib_ready && t < 50) begin
         @(negedge Clk);
         t++;
      end
      if (t >= 50) check("nib_timeout", 32'd0, 32'd1);
      @(negedge Clk);
      bus.nib_valid = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      send_nib(b[7:4]);
      send_nib(b[3:0]);
   endtask

   task automatic do_start(input logic [ADDR_W-1:0] b, input logic [LEN_W-1:0] l);
      @(negedge Clk);
      start = 1'b1;
      base  = b;
      len   = l;
      @(negedge Clk);
      start = 1'b0;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while (busy && t < 100) begin
         @(negedge Clk);
         t++;
      end
      if (t >= 100) check("idle_timeout", 32'd0, 32'd1);
   endtask

   int w0, d0, b0;
   int gap;

   initial begin
      n_checks      = 0;
      n_fail        = 0;
      reset         = 1'b1;
      start         = 1'b0;
      base          = '0;
      len           = '0;
      abort         = 1'b0;
      bus.nib_valid = 1'b0;
      bus.nib       = 4'h0;
      repeat (3) @(negedge Clk);
      reset = 1'b0;
      @(negedge Clk);

      // Reset state
      check("rst_ready", {31'd0, bus.nib_ready}, 32'd0);
      check("rst_we",    {31'd0, bus.mem_we},    32'd0);
      check("rst_addr",  {20'd0, bus.mem_addr},  32'd0);
      check("rst_wdata", {24'd0, bus.mem_wdata}, 32'd0);
      check("rst_busy",  {31'd0, busy},          32'd0);
      check("rst_done",  {31'd0, done},          32'd0);
      check("rst_count", {19'd0, count},         32'd0);
      check("rst_csum",  {24'd0, csum},          32'd0);

      // Basic load, back-to-back nibbles
      w0 = wr_n; d0 = done_n;
      do_start(12'h010, 13'd3);
      send_byte(8'h12);
      send_byte(8'h34);
      send_byte(8'h56);
      wait_idle();
      check("basic_nwr",  wr_n - w0, 32'd3);
      check("basic_w0",   {12'd0, wr_log[w0]},     {12'd0, 12'h010, 8'h12});
      check("basic_w1",   {12'd0, wr_log[w0 + 1]}, {12'd0, 12'h011, 8'h34});
      check("basic_w2",   {12'd0, wr_log[w0 + 2]}, {12'd0, 12'h012, 8'h56});
      check("basic_done", done_n - d0, 32'd1);
      check("basic_count", {19'd0, count}, 32'd3);
      check("basic_csum",  {24'd0, csum}, cs_exp(8'h9C));

      // Address wrap at the top of memory
      w0 = wr_n; d0 = done_n;
      do_start(12'hFFF, 13'd2);
      send_byte(8'hAB);
      send_byte(8'hCD);
      wait_idle();
      check("wrap_nwr", wr_n - w0, 32'd2);
      check("wrap_w0",  {12'd0, wr_log[w0]},     {12'd0, 12'hFFF, 8'hAB});
      check("wrap_w1",  {12'd0, wr_log[w0 + 1]}, {12'd0, 12'h000, 8'hCD});
      check("wrap_done", done_n - d0, 32'd1);
      check("wrap_count", {19'd0, count}, 32'd2);
      check("wrap_csum",  {24'd0, csum}, cs_exp(8'h78));

      // Zero length: done one cycle after start, busy for only that cycle
      w0 = wr_n; d0 = done_n; b0 = busy_n;
      do_start(12'h123, 13'd0);
      check("zero_done_now", {31'd0, done}, 32'd1);
      check("zero_busy_now", {31'd0, busy}, 32'd1);
      @(negedge Clk);
      check("zero_done_after", {31'd0, done}, 32'd0);
      check("zero_busy_after", {31'd0, busy}, 32'd0);
      repeat (3) @(negedge Clk);
      check("zero_nwr",   wr_n - w0, 32'd0);
      check("zero_ndone", done_n - d0, 32'd1);
      check("zero_nbusy", busy_n - b0, 32'd1);
      check("zero_count", {19'd0, count}, 32'd0);
      check("zero_csum",  {24'd0, csum}, 32'd0);

      // Gaps and backpressure: junk offered in IDLE and WRITE must be ignored
      w0 = wr_n; d0 = done_n;
      bus.nib_valid = 1'b1;
      bus.nib       = 4'hF;
      @(negedge Clk);
      check("gap_idle_ready", {31'd0, bus.nib_ready}, 32'd0);
      @(negedge Clk);
      bus.nib_valid = 1'b0;
      do_start(12'h200, 13'd2);
      for (int k = 0; k < 2; k++) begin
         automatic logic [7:0] b = (k == 0) ? 8'h5A : 8'hC3;
         gap = $urandom_range(0, 3);
         repeat (gap) @(negedge Clk);
         send_nib(b[7:4]);
         gap = $urandom_range(1, 3);
         repeat (gap) @(negedge Clk);
         send_nib(b[3:0]);
         check("gap_write_ready", {31'd0, bus.nib_ready}, 32'd0);
         check("gap_write_we",    {31'd0, bus.mem_we},    32'd1);
         check("gap_write_data",  {24'd0, bus.mem_wdata}, {24'd0, b});
         bus.nib_valid = 1'b1;
         bus.nib       = 4'hF;
         @(negedge Clk);
         bus.nib_valid = 1'b0;
      end
      wait_idle();
      check("gap_nwr", wr_n - w0, 32'd2);
      check("gap_w0",  {12'd0, wr_log[w0]},     {12'd0, 12'h200, 8'h5A});
      check("gap_w1",  {12'd0, wr_log[w0 + 1]}, {12'd0, 12'h201, 8'hC3});
      check("gap_hold_addr", {20'd0, bus.mem_addr}, 32'h201);
      check("gap_done", done_n - d0, 32'd1);
      check("gap_csum", {24'd0, csum}, cs_exp(8'h1D));

      // Abort after one byte plus a high nibble, with a nibble also on offer
      w0 = wr_n; d0 = done_n;
      do_start(12'h100, 13'd4);
      send_byte(8'h11);
      send_nib(4'h2);
      abort         = 1'b1;
      bus.nib_valid = 1'b1;
      bus.nib       = 4'h2;
      @(negedge Clk);
      abort         = 1'b0;
      bus.nib_valid = 1'b0;
      check("abort_busy", {31'd0, busy}, 32'd0);
      repeat (4) @(negedge Clk);
      check("abort_nwr",   wr_n - w0, 32'd1);
      check("abort_w0",    {12'd0, wr_log[w0]}, {12'd0, 12'h100, 8'h11});
      check("abort_done",  done_n - d0, 32'd0);
      check("abort_count", {19'd0, count}, 32'd1);
      check("abort_csum",  {24'd0, csum}, cs_exp(8'h11));

      // Normal load after abort
      w0 = wr_n; d0 = done_n;
      do_start(12'h300, 13'd1);
      send_byte(8'h7E);
      wait_idle();
      check("post_nwr",   wr_n - w0, 32'd1);
      check("post_w0",    {12'd0, wr_log[w0]}, {12'd0, 12'h300, 8'h7E});
      check("post_done",  done_n - d0, 32'd1);
      check("post_count", {19'd0, count}, 32'd1);

      // Reset asserted right after the low-nibble transfer
      w0 = wr_n;
      do_start(12'h050, 13'd2);
      send_nib(4'h9);
      bus.nib_valid = 1'b1;
      bus.nib       = 4'h8;
      @(posedge Clk);
      #1 reset = 1'b1;
      #1;
      check("mrst_we",    {31'd0, bus.mem_we},    32'd0);
      check("mrst_ready", {31'd0, bus.nib_ready}, 32'd0);
      check("mrst_addr",  {20'd0, bus.mem_addr},  32'd0);
      check("mrst_wdata", {24'd0, bus.mem_wdata}, 32'd0);
      check("mrst_busy",  {31'd0, busy},          32'd0);
      check("mrst_count", {19'd0, count},         32'd0);
      check("mrst_csum",  {24'd0, csum},          32'd0);
      bus.nib_valid = 1'b0;
      repeat (2) @(negedge Clk);
      reset = 1'b0;
      repeat (2) @(negedge Clk);
      check("mrst_nwr", wr_n - w0, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
